// File: rtl/eth_phy_10g_pkg.sv
// Shared constants, types and helpers for the 10G BASE-R PHY transmit path.
package eth_phy_10g_pkg;

  localparam int BLOCK_W   = 64;
  localparam int SYNC_W    = 2;
  localparam int PRBS_BITS = BLOCK_W + SYNC_W;

  localparam logic [SYNC_W-1:0] SYNC_DATA = 2'b01;
  localparam logic [SYNC_W-1:0] SYNC_CTRL = 2'b10;

  localparam int SCR_W  = 58;
  localparam int PRBS_W = 31;

  localparam logic [SCR_W-1:0]  SCRAMBLER_SEED = {SCR_W{1'b1}};
  localparam logic [PRBS_W-1:0] PRBS31_SEED    = {PRBS_W{1'b1}};

  localparam int SCR_TAP_A  = 38;
  localparam int SCR_TAP_B  = 57;
  localparam int PRBS_TAP_A = 27;
  localparam int PRBS_TAP_B = 30;

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_PRBS   = 1'b1
  } tx_mode_e;

  typedef struct packed {
    logic [BLOCK_W-1:0] data;
    logic [SYNC_W-1:0]  hdr;
    logic               bad;
  } tx_word_t;

  function automatic logic hdr_valid(input logic [SYNC_W-1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

  function automatic logic [BLOCK_W-1:0] reverse_data(input logic [BLOCK_W-1:0] d);
    logic [BLOCK_W-1:0] r;
    for (int i = 0; i < BLOCK_W; i++) r[BLOCK_W-1-i] = d[i];
    return r;
  endfunction

endpackage

// File: rtl/eth_lfsr_unroll.sv
// One clock's worth of a two-tap LFSR, unrolled over N_BITS serial steps.
// SELF_SYNC=1 feeds the output bit back (scrambler); 0 feeds the tap XOR back (generator).
module eth_lfsr_unroll
  import eth_phy_10g_pkg::*;
#(
  parameter int STATE_W   = SCR_W,
  parameter int TAP_A     = SCR_TAP_A,
  parameter int TAP_B     = SCR_TAP_B,
  parameter int N_BITS    = BLOCK_W,
  parameter bit SELF_SYNC = 1'b1
) (
  input  logic [STATE_W-1:0] state,
  input  logic [N_BITS-1:0]  data,
  output logic [N_BITS-1:0]  bits,
  output logic [STATE_W-1:0] next_state
);

  logic [STATE_W-1:0] s;
  logic               fb;

  // NOTE: blocking assignments here are deliberate: each loop iteration must see
  // the state left by the previous one, which builds the serial chain in logic.
  always_comb begin
    s    = state;
    fb   = 1'b0;
    bits = '0;
    for (int i = 0; i < N_BITS; i++) begin
      fb      = s[TAP_A] ^ s[TAP_B];
      bits[i] = data[i] ^ fb;
      s       = {s[STATE_W-2:0], SELF_SYNC ? bits[i] : fb};
    end
    next_state = s;
  end

endmodule

// File: rtl/eth_phy_10g_tx_if.sv
// 10G BASE-R transmit SERDES interface: scrambles or replaces blocks with PRBS31,
// optionally bit-reverses, and registers them through a configurable pipeline.
module eth_phy_10g_tx_if
  import eth_phy_10g_pkg::*;
#(
  parameter int DATA_WIDTH        = 64,
  parameter int HDR_WIDTH         = 2,
  parameter int BIT_REVERSE       = 0,
  parameter int SCRAMBLER_DISABLE = 0,
  parameter int PRBS31_ENABLE     = 0,
  parameter int SERDES_PIPELINE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] encoded_tx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
  output logic [DATA_WIDTH-1:0] serdes_tx_data,
  output logic [HDR_WIDTH-1:0]  serdes_tx_hdr,
  output logic                  tx_bad_hdr,
  output logic [7:0]            tx_bad_hdr_count,
  input  logic                  cfg_tx_prbs31_enable
);

  tx_mode_e             mode;
  logic [BLOCK_W-1:0]   scr_data;
  logic [PRBS_BITS-1:0] prbs_bits;
  tx_word_t             stage_in;
  tx_word_t             pipe [0:SERDES_PIPELINE];
  logic                 bad_to_out;

  assign mode = ((PRBS31_ENABLE != 0) && cfg_tx_prbs31_enable) ? MODE_PRBS : MODE_NORMAL;

  generate
    if (SCRAMBLER_DISABLE == 0) begin : g_scr
      logic [SCR_W-1:0] scr_state;
      logic [SCR_W-1:0] scr_next;

      eth_lfsr_unroll #(
        .STATE_W  (SCR_W),
        .TAP_A    (SCR_TAP_A),
        .TAP_B    (SCR_TAP_B),
        .N_BITS   (BLOCK_W),
        .SELF_SYNC(1'b1)
      ) u_scr (
        .state     (scr_state),
        .data      (encoded_tx_data),
        .bits      (scr_data),
        .next_state(scr_next)
      );

      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      always_ff @(posedge clk) begin
        if (!rst_n)                   scr_state <= SCRAMBLER_SEED;
        else if (mode == MODE_NORMAL) scr_state <= scr_next;
      end
    end else begin : g_no_scr
      assign scr_data = encoded_tx_data;
    end

    if (PRBS31_ENABLE != 0) begin : g_prbs
      logic [PRBS_W-1:0] prbs_state;
      logic [PRBS_W-1:0] prbs_next;

      // Feeding all ones as data yields the inverted generator output directly.
      eth_lfsr_unroll #(
        .STATE_W  (PRBS_W),
        .TAP_A    (PRBS_TAP_A),
        .TAP_B    (PRBS_TAP_B),
        .N_BITS   (PRBS_BITS),
        .SELF_SYNC(1'b0)
      ) u_prbs (
        .state     (prbs_state),
        .data      ({PRBS_BITS{1'b1}}),
        .bits      (prbs_bits),
        .next_state(prbs_next)
      );

      always_ff @(posedge clk) begin
        if (!rst_n)                 prbs_state <= PRBS31_SEED;
        else if (mode == MODE_PRBS) prbs_state <= prbs_next;
      end
    end else begin : g_no_prbs
      assign prbs_bits = '0;
    end
  endgenerate

  always_comb begin
    stage_in = '0;
    if (mode == MODE_PRBS) begin
      stage_in.data = prbs_bits[PRBS_BITS-1:SYNC_W];
      stage_in.hdr  = prbs_bits[SYNC_W-1:0];
    end else begin
      stage_in.data = scr_data;
      stage_in.hdr  = encoded_tx_hdr;
      stage_in.bad  = !hdr_valid(encoded_tx_hdr);
    end
    if (BIT_REVERSE != 0) begin
      stage_in.data = reverse_data(stage_in.data);
      stage_in.hdr  = {stage_in.hdr[0], stage_in.hdr[1]};
    end
  end

  // NOTE: the pipeline is a handful of flops, not a RAM, so every stage is reset;
  // this keeps outputs at their reset values until the first real block arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= SERDES_PIPELINE; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= stage_in;
      for (int i = 1; i <= SERDES_PIPELINE; i++) pipe[i] <= pipe[i-1];
    end
  end

  // The counter looks one stage ahead so it changes together with the visible pulse.
  generate
    if (SERDES_PIPELINE == 0) begin : g_cnt_direct
      assign bad_to_out = stage_in.bad;
    end else begin : g_cnt_piped
      assign bad_to_out = pipe[SERDES_PIPELINE-1].bad;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n)                                       tx_bad_hdr_count <= '0;
    else if (bad_to_out && (tx_bad_hdr_count != 8'hFF)) tx_bad_hdr_count <= tx_bad_hdr_count + 8'd1;
  end

  assign serdes_tx_data = pipe[SERDES_PIPELINE].data;
  assign serdes_tx_hdr  = pipe[SERDES_PIPELINE].hdr;
  assign tx_bad_hdr     = pipe[SERDES_PIPELINE].bad;

endmodule

// File: tb/tb_eth_phy_10g_tx_if.sv
// Bench for eth_phy_10g_tx_if: two configurations driven in lockstep and compared
// against a bit-stream reference model of the scrambler, PRBS31 and bad-header counter.
module tb_eth_phy_10g_tx_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg = 1'b0;
  logic [63:0] din = '0;
  logic [1:0]  hin = 2'b01;

  logic [63:0] a_data, b_data;
  logic [1:0]  a_hdr, b_hdr;
  logic        a_bad, b_bad;
  logic [7:0]  a_cnt, b_cnt;

  always #5 clk = ~clk;

  // Config A: scrambler on, PRBS available, no reverse, latency 1.
  eth_phy_10g_tx_if #(
    .PRBS31_ENABLE(1)
  ) dut_a (
    .clk                 (clk),
    .rst_n               (rst_n),
    .encoded_tx_data     (din),
    .encoded_tx_hdr      (hin),
    .serdes_tx_data      (a_data),
    .serdes_tx_hdr       (a_hdr),
    .tx_bad_hdr          (a_bad),
    .tx_bad_hdr_count    (a_cnt),
    .cfg_tx_prbs31_enable(cfg)
  );

  // Config B: scrambler off, bit reverse, two extra stages (latency 3).
  eth_phy_10g_tx_if #(
    .BIT_REVERSE      (1),
    .SCRAMBLER_DISABLE(1),
    .PRBS31_ENABLE    (1),
    .SERDES_PIPELINE  (2)
  ) dut_b (
    .clk                 (clk),
    .rst_n               (rst_n),
    .encoded_tx_data     (din),
    .encoded_tx_hdr      (hin),
    .serdes_tx_data      (b_data),
    .serdes_tx_hdr       (b_hdr),
    .tx_bad_hdr          (b_bad),
    .tx_bad_hdr_count    (b_cnt),
    .cfg_tx_prbs31_enable(cfg)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  hdr;
    logic        bad;
    logic [7:0]  cnt;
    logic [63:0] src;
    bit          normal;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  bit   scr_hist[$];   // transmitted scrambled bits, newest at the back
  bit   prbs_hist[$];  // raw generator bits, newest at the back
  bit   rx_hist[$];    // received bits for the descrambler
  int   bad_cnt;
  int   rx_blocks;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    vectors++;
    assert (obs === expd) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expd);
    end
  endtask

  function automatic void model_reset();
    scr_hist.delete();
    prbs_hist.delete();
    repeat (58) scr_hist.push_back(1'b1);
    repeat (31) prbs_hist.push_back(1'b1);
    bad_cnt   = 0;
    rx_blocks = 0;
  endfunction

  // out_n = d_n ^ out_(n-39) ^ out_(n-58)
  function automatic logic [63:0] scramble(input logic [63:0] d);
    logic [63:0] r;
    bit o;
    for (int i = 0; i < 64; i++) begin
      o = d[i] ^ scr_hist[scr_hist.size()-39] ^ scr_hist[scr_hist.size()-58];
      r[i] = o;
      scr_hist.push_back(o);
      void'(scr_hist.pop_front());
    end
    return r;
  endfunction

  // b_n = b_(n-31) ^ b_(n-28); emitted inverted
  function automatic logic [65:0] prbs_block();
    logic [65:0] r;
    bit b;
    for (int i = 0; i < 66; i++) begin
      b = prbs_hist[prbs_hist.size()-31] ^ prbs_hist[prbs_hist.size()-28];
      r[i] = ~b;
      prbs_hist.push_back(b);
      void'(prbs_hist.pop_front());
    end
    return r;
  endfunction

  function automatic logic [63:0] descramble(input logic [63:0] o);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) begin
      r[i] = o[i] ^ rx_hist[rx_hist.size()-39] ^ rx_hist[rx_hist.size()-58];
      rx_hist.push_back(o[i]);
      void'(rx_hist.pop_front());
    end
    return r;
  endfunction

  function automatic logic [63:0] rev64(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[63-i] = d[i];
    return r;
  endfunction

  task automatic compare();
    exp_t e;
    logic [63:0] plain;
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      check("a_data", a_data, e.data);
      check("a_hdr", {62'b0, a_hdr}, {62'b0, e.hdr});
      check("a_bad", {63'b0, a_bad}, {63'b0, e.bad});
      check("a_cnt", {56'b0, a_cnt}, {56'b0, e.cnt});
      if (e.normal) begin
        plain = descramble(a_data);
        if (rx_blocks > 0) check("roundtrip", plain, e.src);
        rx_blocks++;
      end
    end
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      check("b_data", b_data, e.data);
      check("b_hdr", {62'b0, b_hdr}, {62'b0, e.hdr});
      check("b_bad", {63'b0, b_bad}, {63'b0, e.bad});
      check("b_cnt", {56'b0, b_cnt}, {56'b0, e.cnt});
    end
  endtask

  task automatic cycle(input logic [63:0] d, input logic [1:0] h, input bit prbs);
    exp_t ea, eb;
    logic [65:0] p;
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    din   = d;
    hin   = h;
    cfg   = prbs;
    ea.src = d;
    eb.src = d;
    if (prbs) begin
      p = prbs_block();
      ea.data = p[65:2];
      ea.hdr  = p[1:0];
      ea.bad  = 1'b0;
      ea.normal = 1'b0;
    end else begin
      ea.data = scramble(d);
      ea.hdr  = h;
      ea.bad  = (h == 2'b00) || (h == 2'b11);
      ea.normal = 1'b1;
      if (ea.bad && bad_cnt < 255) bad_cnt++;
    end
    ea.cnt = 8'(bad_cnt);
    eb.data = rev64(prbs ? p[65:2] : d);
    eb.hdr  = prbs ? {p[0], p[1]} : {h[0], h[1]};
    eb.bad  = ea.bad;
    eb.cnt  = ea.cnt;
    eb.normal = 1'b0;
    exp_a.push_back(ea);
    exp_b.push_back(eb);
  endtask

  // Holds rst_n low across exactly one rising edge; reset values are then expected
  // until each configuration's latency has elapsed.
  task automatic do_reset();
    exp_t z;
    @(negedge clk);
    compare();
    rst_n = 1'b0;
    exp_a.delete();
    exp_b.delete();
    model_reset();
    z.data = '0; z.hdr = 2'b00; z.bad = 1'b0; z.cnt = '0; z.src = '0; z.normal = 1'b0;
    exp_a.push_back(z);
    repeat (3) exp_b.push_back(z);
  endtask

  function automatic logic [1:0] rand_valid_hdr();
    return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
  endfunction

  initial begin
    repeat (58) rx_hist.push_back(1'b0);
    model_reset();
    do_reset();

    // Seed check on A, then bit-reverse check on B.
    cycle(64'h0, 2'b01, 1'b0);
    cycle(64'h1, 2'b01, 1'b0);
    check("seed_low40", {24'b0, a_data[39:0]}, 64'h0000_0080_0000_0000);
    check("seed_hdr", {62'b0, a_hdr}, 64'h1);
    cycle(64'h0, 2'b01, 1'b0);
    cycle(64'h0, 2'b01, 1'b0);
    cycle(64'h0, 2'b01, 1'b0);
    check("rev_data", b_data, 64'h8000_0000_0000_0000);
    check("rev_hdr", {62'b0, b_hdr}, 64'h2);

    // Self-synchronous round trip over random traffic.
    for (int i = 0; i < 10000; i++) cycle({$urandom, $urandom}, rand_valid_hdr(), 1'b0);

    // PRBS31 runs, switch back, then random mode toggling with any header.
    for (int i = 0; i < 200; i++) cycle({$urandom, $urandom}, rand_valid_hdr(), 1'b1);
    for (int i = 0; i < 200; i++) cycle({$urandom, $urandom}, rand_valid_hdr(), 1'b0);
    for (int i = 0; i < 200; i++)
      cycle({$urandom, $urandom}, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);

    // Bad headers from a clean count.
    do_reset();
    cycle({$urandom, $urandom}, 2'b00, 1'b0);
    cycle({$urandom, $urandom}, 2'b01, 1'b0);
    check("bad_first_pulse", {63'b0, a_bad}, 64'h1);
    check("bad_first_cnt", {56'b0, a_cnt}, 64'd1);
    for (int i = 0; i < 300; i++) cycle({$urandom, $urandom}, 2'b11, 1'b0);
    cycle({$urandom, $urandom}, 2'b10, 1'b0);
    check("bad_sat_pulse", {63'b0, a_bad}, 64'h1);
    check("bad_sat_cnt", {56'b0, a_cnt}, 64'd255);

    // Reset in the middle of traffic, then the seed block again.
    for (int i = 0; i < 20; i++) cycle({$urandom, $urandom}, rand_valid_hdr(), 1'b0);
    do_reset();
    cycle(64'h0, 2'b01, 1'b0);
    cycle(64'h0, 2'b01, 1'b0);
    check("reseed_low40", {24'b0, a_data[39:0]}, 64'h0000_0080_0000_0000);
    check("reseed_hdr", {62'b0, a_hdr}, 64'h1);
    check("reseed_cnt", {56'b0, a_cnt}, 64'd0);
    for (int i = 0; i < 50; i++) cycle({$urandom, $urandom}, rand_valid_hdr(), 1'b0);

    // Drain in-flight expectations.
    repeat (4) cycle(64'h0, 2'b01, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
